// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the 8-bit bus computer control sequencer:
// module-select codes, opcodes, ALU ops, control-word layout and FSM states.
package control_sequencer_pkg;

    localparam logic [3:0] SEL_PC   = 4'h0;
    localparam logic [3:0] SEL_ACC  = 4'h1;
    localparam logic [3:0] SEL_BREG = 4'h2;
    localparam logic [3:0] SEL_ALU  = 4'h3;
    localparam logic [3:0] SEL_MAR  = 4'h4;
    localparam logic [3:0] SEL_MEM  = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h6;
    localparam logic [3:0] SEL_OR   = 4'h8;
    localparam logic [3:0] IDLE_SEL_DEFAULT = 4'hF;

    typedef enum logic [3:0] {
        OPC_LDA = 4'b0000,
        OPC_ADD = 4'b0001,
        OPC_SUB = 4'b0010,
        OPC_OUT = 4'b1110,
        OPC_HLT = 4'b1111
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef struct packed {
        logic [3:0] sel;
        logic       oe;
        logic       we;
        logic [2:0] op;
        logic       en;
        logic       last;
        logic       mem_wait;
    } ctrl_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_STEP,
        ST_HALTED
    } state_e;

    function automatic ctrl_word_t cw(input logic [3:0] sel, input logic oe, input logic we,
                                      input logic [2:0] op, input logic en, input logic last,
                                      input logic mem_wait);
        ctrl_word_t c;
        c.sel      = sel;
        c.oe       = oe;
        c.we       = we;
        c.op       = op;
        c.en       = en;
        c.last     = last;
        c.mem_wait = mem_wait;
        return c;
    endfunction

    // Opcodes that have an execute phase after the fetch steps.
    function automatic logic has_exec(input logic [3:0] opc);
        return opc inside {OPC_LDA, OPC_ADD, OPC_SUB, OPC_OUT};
    endfunction

endpackage

// File: rtl/control_sequencer_rom.sv
// Microcode ROM: combinational (opcode, step) -> control word with LAST/WAIT flags.
module control_rom
    import control_sequencer_pkg::*;
#(
    parameter logic [3:0] IDLE_SEL = IDLE_SEL_DEFAULT
) (
    input  logic [3:0] opcode,
    input  logic [3:0] step,
    output ctrl_word_t word
);

    logic [2:0] alu_op;

    assign alu_op = (opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;

    always_comb begin
        word = cw(IDLE_SEL, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b1, 1'b0);
        case (step)
            4'd0: word = cw(SEL_PC,  1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0);
            4'd1: word = cw(SEL_MAR, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0);
            4'd2: word = cw(SEL_MEM, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
            4'd3: word = cw(SEL_IR,  1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0);
            4'd4: word = cw(IDLE_SEL, 1'b0, 1'b0, ALU_ADD, 1'b1, !has_exec(opcode), 1'b0);
            default: begin
                case (opcode)
                    OPC_LDA, OPC_ADD, OPC_SUB: begin
                        case (step)
                            4'd5: word = cw(SEL_IR,  1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0);
                            4'd6: word = cw(SEL_MAR, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0);
                            4'd7: word = cw(SEL_MEM, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1);
                            4'd8: word = (opcode == OPC_LDA)
                                       ? cw(SEL_ACC,  1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0)
                                       : cw(SEL_BREG, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0);
                            4'd9: if (opcode != OPC_LDA)
                                      word = cw(SEL_ALU, 1'b1, 1'b0, alu_op, 1'b0, 1'b0, 1'b0);
                            4'd10: if (opcode != OPC_LDA)
                                      word = cw(SEL_ACC, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0);
                            default: ;
                        endcase
                    end
                    OPC_OUT: begin
                        case (step)
                            4'd5: word = cw(SEL_ACC, 1'b1, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0);
                            4'd6: word = cw(SEL_OR,  1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0);
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded fetch/execute sequencer for the 8-bit bus computer.
// Optional single-step mode: define CONTROL_SEQUENCER_STEP_MODE_EN to add the STEP input.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 1023,
    parameter logic [3:0]  IDLE_SEL    = 4'hF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RUN,
    input  logic [3:0] IR_OPCODE,
    input  logic       MEM_DONE,
`ifdef CONTROL_SEQUENCER_STEP_MODE_EN
    input  logic       STEP,
`endif
    output logic [3:0] SEL,
    output logic       OE,
    output logic       WE,
    output logic [2:0] OP,
    output logic       EN,
    output logic       HLT,
    output logic [3:0] STEP_IDX,
    output logic       BUSY,
    output logic       ERR
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);
    localparam ctrl_word_t IDLE_WORD = cw(IDLE_SEL, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0);

    state_e        state;
    ctrl_word_t    word_q;
    logic [3:0]    step_q;
    logic [3:0]    opcode_q;
    logic [CW-1:0] tmo_cnt;
    logic          hlt_q;
    logic          busy_q;
    logic          err_q;

    logic [3:0]    rom_op;
    logic [3:0]    nxt_step;
    ctrl_word_t    nxt_word;
    logic          go;

`ifdef CONTROL_SEQUENCER_STEP_MODE_EN
    logic step_d;

    always_ff @(posedge CLK) begin
        if (!RESET_N) step_d <= 1'b0;
        else          step_d <= STEP;
    end

    assign go = STEP & ~step_d;
`else
    assign go = 1'b1;
`endif

    // The opcode is only valid from step 4 onward; the latched copy takes over after that.
    // Step 4's LAST flag was looked up before IR was loaded, so decide the branch here instead.
    assign rom_op = (step_q == 4'd4) ? IR_OPCODE : opcode_q;

    always_comb begin
        nxt_step = '0;
        if (state == ST_RUN_STEP) begin
            if (step_q == 4'd4)
                nxt_step = has_exec(IR_OPCODE) ? 4'd5 : 4'd0;
            else if (!word_q.last)
                nxt_step = step_q + 4'd1;
        end
    end

    control_rom #(.IDLE_SEL(IDLE_SEL)) u_rom (
        .opcode (rom_op),
        .step   (nxt_step),
        .word   (nxt_word)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            word_q   <= IDLE_WORD;
            step_q   <= '0;
            opcode_q <= '0;
            tmo_cnt  <= '0;
            hlt_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (RUN) begin
                        state   <= ST_RUN_STEP;
                        word_q  <= nxt_word;
                        step_q  <= '0;
                        tmo_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN_STEP: begin
                    if (word_q.mem_wait && !MEM_DONE) begin
                        if (tmo_cnt == TMO_LAST) begin
                            state  <= ST_HALTED;
                            word_q <= IDLE_WORD;
                            step_q <= '0;
                            hlt_q  <= 1'b1;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + CW'(1);
                        end
                    end else if (go) begin
                        tmo_cnt <= '0;
                        if (step_q == 4'd4) opcode_q <= IR_OPCODE;
                        if (step_q == 4'd4 && IR_OPCODE == OPC_HLT) begin
                            state  <= ST_HALTED;
                            word_q <= IDLE_WORD;
                            step_q <= '0;
                            hlt_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            word_q <= nxt_word;
                            step_q <= nxt_step;
                        end
                    end
                end
                ST_HALTED: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SEL      = word_q.sel;
    assign OE       = word_q.oe;
    assign WE       = word_q.we;
    assign OP       = word_q.op;
    assign EN       = word_q.en;
    assign HLT      = hlt_q;
    assign STEP_IDX = step_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: queue-based micro-op model compared every cycle,
// plus directed literal checks for the LDA/ADD/OUT/HLT/timeout/reset scenarios.
`timescale 1ns/1ps
module tb_control_sequencer;

    localparam int unsigned TMO = 8;

    logic       CLK = 1'b0;
    logic       RESET_N, RUN, MEM_DONE;
    logic [3:0] IR_OPCODE;
    logic [3:0] SEL;
    logic       OE, WE;
    logic [2:0] OP;
    logic       EN, HLT;
    logic [3:0] STEP_IDX;
    logic       BUSY, ERR;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    control_sequencer #(.MEM_TIMEOUT(TMO), .IDLE_SEL(4'hF)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RUN       (RUN),
        .IR_OPCODE (IR_OPCODE),
        .MEM_DONE  (MEM_DONE),
        .SEL       (SEL),
        .OE        (OE),
        .WE        (WE),
        .OP        (OP),
        .EN        (EN),
        .HLT       (HLT),
        .STEP_IDX  (STEP_IDX),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    // Model: the current instruction is a queue of bus transfers {sel, oe, we, op, en}.
    logic [9:0] uq[$];
    int         m_mode = 0;   // 0 idle, 1 running, 2 halted
    int         m_idx  = 0;
    int         m_held = 0;
    bit         m_err  = 1'b0;
    bit         armed  = 1'b0;

    task automatic push(input int s, input int oe, input int we, input int op, input int en);
        uq.push_back({4'(s), 1'(oe), 1'(we), 3'(op), 1'(en)});
    endtask

    task automatic load_fetch();
        uq.delete();
        push(0, 1, 0, 0, 0);
        push(4, 0, 1, 0, 0);
        push(5, 1, 0, 0, 0);
        push(6, 0, 1, 0, 0);
        push(15, 0, 0, 0, 1);
    endtask

    task automatic push_exec(input int opc);
        if (opc == 0 || opc == 1 || opc == 2) begin
            push(6, 1, 0, 0, 0);
            push(4, 0, 1, 0, 0);
            push(5, 1, 0, 0, 0);
            if (opc == 0) begin
                push(1, 0, 1, 0, 0);
            end else begin
                push(2, 0, 1, 0, 0);
                push(3, 1, 0, opc - 1, 0);
                push(1, 0, 1, 0, 0);
            end
        end else if (opc == 14) begin
            push(1, 1, 0, 0, 0);
            push(8, 0, 1, 0, 0);
        end
    endtask

    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_mode = 0;
            uq.delete();
            m_idx  = 0;
            m_held = 0;
            m_err  = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            if (m_mode == 0) begin
                if (RUN) begin
                    m_mode = 1;
                    load_fetch();
                    m_idx  = 0;
                    m_held = 0;
                end
            end else if (m_mode == 1) begin
                if (uq[0][9:6] == 4'd5 && uq[0][5] && !MEM_DONE) begin
                    m_held++;
                    if (m_held == int'(TMO)) begin
                        m_mode = 2;
                        m_err  = 1'b1;
                    end
                end else begin
                    m_held = 0;
                    void'(uq.pop_front());
                    if (m_idx == 4) begin
                        if (IR_OPCODE == 4'd15) m_mode = 2;
                        else                    push_exec(int'(IR_OPCODE));
                    end
                    m_idx++;
                    if (m_mode == 1 && uq.size() == 0) begin
                        load_fetch();
                        m_idx = 0;
                    end
                end
            end
        end
    end

    logic [16:0] exp_v, act_v;

    always @(negedge CLK) begin
        if (armed) begin
            if (m_mode == 1)
                exp_v = {uq[0], 1'b0, 4'(m_idx), 1'b1, m_err};
            else
                exp_v = {4'hF, 1'b0, 1'b0, 3'b000, 1'b0, (m_mode == 2), 4'd0, 1'b0, m_err};
            act_v = {SEL, OE, WE, OP, EN, HLT, STEP_IDX, BUSY, ERR};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // {SEL, OE, WE, EN} for each cycle of an LDA with MEM_DONE tied high.
    logic [6:0] lda_exp [10] = '{
        7'b0000_100, 7'b0100_010, 7'b0101_100, 7'b0110_010, 7'b1111_001,
        7'b0110_100, 7'b0100_010, 7'b0101_100, 7'b0001_010, 7'b0000_100
    };

    initial begin
        int r;
        RESET_N   = 1'b0;
        RUN       = 1'b0;
        MEM_DONE  = 1'b1;
        IR_OPCODE = 4'd0;
        repeat (2) @(negedge CLK);
        chk("reset_sel", 32'(SEL), 32'hF);
        chk("reset_ctl", 32'({OE, WE, EN, HLT, BUSY, ERR, OP}), 32'h0);
        chk("reset_step", 32'(STEP_IDX), 32'h0);

        RESET_N = 1'b1;
        RUN     = 1'b1;
        @(negedge CLK);
        RUN = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("lda_word", 32'({SEL, OE, WE, EN}), 32'(lda_exp[c]));
            chk("lda_step", 32'(STEP_IDX), 32'(c % 9));
            if (c < 9) @(negedge CLK);
        end

        IR_OPCODE = 4'd1;
        for (int c = 0; c <= 15; c++) begin
            MEM_DONE = (c == 4 || c == 11);
            if (c >= 2 && c <= 4)  chk("add_fetch_wait", 32'({SEL, STEP_IDX}), 32'h52);
            if (c >= 9 && c <= 11) chk("add_exec_wait", 32'({SEL, STEP_IDX}), 32'h57);
            if (c == 13) chk("add_alu", 32'({SEL, OE, WE, OP}), 32'({4'd3, 1'b1, 1'b0, 3'b000}));
            if (c == 15) chk("add_length", 32'({SEL, OE, STEP_IDX}), 32'({4'd0, 1'b1, 4'd0}));
            if (c < 15) @(negedge CLK);
        end

        IR_OPCODE = 4'd14;
        MEM_DONE  = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c == 7) IR_OPCODE = 4'd15;
            RUN = (c == 13);
            if (c == 5) chk("out_acc_oe", 32'({SEL, OE, WE}), 32'({4'd1, 1'b1, 1'b0}));
            if (c == 6) chk("out_or_we", 32'({SEL, OE, WE}), 32'({4'd8, 1'b0, 1'b1}));
            if (c == 11) chk("hlt_step4", 32'({SEL, EN, STEP_IDX}), 32'({4'hF, 1'b1, 4'd4}));
            if (c >= 12) chk("halted", 32'({HLT, BUSY, SEL, STEP_IDX, ERR}), 32'({1'b1, 1'b0, 4'hF, 4'd0, 1'b0}));
            if (c < 15) @(negedge CLK);
        end

        RESET_N = 1'b0;
        RUN     = 1'b0;
        @(negedge CLK);
        chk("halt_reset", 32'({HLT, BUSY, SEL, ERR}), 32'({1'b0, 1'b0, 4'hF, 1'b0}));
        RESET_N  = 1'b1;
        RUN      = 1'b1;
        MEM_DONE = 1'b0;
        @(negedge CLK);
        RUN = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            RUN      = (c == 10 || c == 11);
            MEM_DONE = (c >= 10);
            if (c >= 2 && c <= 9) chk("tmo_hold", 32'({SEL, STEP_IDX, ERR, HLT}), 32'({4'd5, 4'd2, 1'b0, 1'b0}));
            if (c >= 10) chk("tmo_err", 32'({ERR, HLT, BUSY, SEL}), 32'({1'b1, 1'b1, 1'b0, 4'hF}));
            @(negedge CLK);
        end

        RESET_N  = 1'b0;
        RUN      = 1'b0;
        MEM_DONE = 1'b0;
        @(negedge CLK);
        chk("err_reset", 32'({ERR, HLT, BUSY}), 32'h0);
        RESET_N = 1'b1;
        RUN     = 1'b1;
        @(negedge CLK);
        RUN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("wait_before_reset", 32'({SEL, STEP_IDX, BUSY}), 32'({4'd5, 4'd2, 1'b1}));
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("reset_in_wait", 32'({SEL, OE, STEP_IDX, BUSY}), 32'({4'hF, 1'b0, 4'd0, 1'b0}));
        @(negedge CLK);
        chk("reset_in_wait2", 32'({SEL, OE, STEP_IDX, BUSY}), 32'({4'hF, 1'b0, 4'd0, 1'b0}));
        RESET_N  = 1'b1;
        RUN      = 1'b1;
        MEM_DONE = 1'b1;
        @(negedge CLK);
        RUN = 1'b0;
        chk("restart_step0", 32'({SEL, OE, STEP_IDX, BUSY}), 32'({4'd0, 1'b1, 4'd0, 1'b1}));

        for (int i = 0; i < 4000; i++) begin
            bit low_done;
            low_done = ((i / 300) % 3 == 2);
            RESET_N  = (m_mode == 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) != 0);
            RUN      = ($urandom_range(0, 3) == 0);
            MEM_DONE = low_done ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 15));
            if (r < 4)       IR_OPCODE = 4'd0;
            else if (r < 8)  IR_OPCODE = 4'd1;
            else if (r < 11) IR_OPCODE = 4'd2;
            else if (r < 13) IR_OPCODE = 4'd14;
            else if (r == 13) IR_OPCODE = 4'd15;
            else             IR_OPCODE = 4'($urandom_range(3, 13));
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Controller/sequencer (module-select code CNTRL) for the 8-bit bus computer.
- Sits directly upstream of the computer top level and replaces the manual SEL/OE/WE/OP/EN/HLT switches with a microcoded control word, one bus transfer per cycle.
- Runs the fetch cycle, decodes the opcode latched from the instruction register, and executes the LDA/ADD/SUB/OUT/HLT micro-sequences.
- Waits on the EEPROM completion handshake during memory reads.

Parameters:
- MEM_TIMEOUT, 1023: maximum cycles to wait for MEM_DONE before aborting; must be at least 1.
- IDLE_SEL, 4'hF: SEL value driven when no module is addressed (unused code).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- RUN  input  1  start request; sampled only in IDLE.
- IR_OPCODE  input  4  opcode field (IR[7:4]) from the instruction register.
- MEM_DONE  input  1  EEPROM read complete.
- SEL  output  4  module select: PC=0, ACC=1, BREG=2, ALU=3, MAR=4, MEM=5, IR=6, OR=8.
- OE  output  1  selected module drives the bus.
- WE  output  1  selected module loads from the bus.
- OP  output  3  ALU op code: ADD=000, SUB=001.
- EN  output  1  program-counter increment strobe.
- HLT  output  1  halt indication.
- STEP_IDX  output  4  current micro-step number.
- BUSY  output  1  high when not IDLE and not HALTED.
- ERR  output  1  sticky memory-timeout flag.

Behaviour:
- All outputs are registered.
- Reset values, applied on the first CLK edge with RESET_N=0, overriding everything including a MEM wait: SEL=IDLE_SEL, OE=WE=EN=HLT=BUSY=ERR=0, OP=000, STEP_IDX=0. State goes to IDLE, opcode latch and timeout counter are cleared.
- States:
  - IDLE: outputs at reset values. RUN=1 moves to RUN_STEP; the control word for step 0 appears on the following edge (1-cycle latency).
  - RUN_STEP: one micro-step per cycle. OE and WE are never asserted together. Each micro-step drives exactly one SEL with OE or WE, or asserts EN alone with SEL=IDLE_SEL.
  - HALTED: HLT=1, BUSY=0, SEL=IDLE_SEL. RUN is ignored; the only exit is reset.
- Fetch sequence, common to all instructions:
  - step 0: PC OE
  - step 1: MAR WE
  - step 2: MEM OE (wait step)
  - step 3: IR WE
  - step 4: EN=1 (increment PC); IR_OPCODE is latched at the end of this step.
- Execute sequences, starting at step 5:
  - LDA 0000: IR OE, MAR WE, MEM OE (wait), ACC WE.
  - ADD 0001: IR OE, MAR WE, MEM OE (wait), BREG WE, ALU OE with OP=000, ACC WE.
  - SUB 0010: same as ADD with OP=001.
  - OUT 1110: ACC OE, OR WE.
  - HLT 1111: enters HALTED directly after step 4.
  - Any other opcode: NOP; returns to step 0.
- After the last execute step, STEP_IDX returns to 0 on the next edge with no dead cycle. OP holds 000 outside the ALU step.
- Wait step:
  - Holds its control word and STEP_IDX while MEM_DONE=0. Each step lasts at least 1 cycle.
  - The step advances on the edge after MEM_DONE is sampled 1.
  - The timeout counter counts held cycles; once MEM_TIMEOUT cycles elapse without MEM_DONE, ERR is set and the state goes to HALTED.
  - A MEM_DONE outside a wait step is ignored.
- A RUN held high or pulsed while BUSY has no effect.

Optional Feature:
- Macro: CONTROL_SEQUENCER_STEP_MODE_EN.
- When defined, a STEP input (1 bit) is added. RUN_STEP advances only on a cycle where a rising edge of STEP is detected (one-cycle registered edge detector). The control word is held between steps, and wait steps additionally require MEM_DONE.
- When undefined, there is no STEP port and the sequencer free-runs.

Decomposition:
- Package control_sequencer_pkg holds:
  - SEL module codes and IDLE_SEL,
  - opcodes (LDA, ADD, SUB, OUT, HLT),
  - ALU op codes,
  - the control-word field layout {SEL, OE, WE, OP, EN, LAST, WAIT}.
- Sub-module control_rom: combinational lookup of (opcode, step) to control word plus LAST/WAIT flags. The top keeps the state machine, step counter, opcode latch, timeout counter and output registers.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles mid-sequence -> SEL=4'hF, OE=WE=EN=HLT=BUSY=ERR=0, STEP_IDX=0.
- LDA, MEM_DONE tied 1, RUN pulse, IR_OPCODE=0000 -> per-cycle SEL/ctl: 0/OE, 4/WE, 5/OE, 6/WE, EN, 6/OE, 4/WE, 5/OE, 1/WE, then 0/OE (9-cycle instruction).
- ADD with MEM_DONE delayed 3 cycles in each wait step -> each MEM step held 3 cycles. At the ALU step: SEL=3, OE=1, OP=000. Total instruction length 11+4 cycles.
- OUT (1110) then HLT (1111) -> ACC OE, OR WE; HLT=1 after step 4 of the second fetch; a RUN pulse is ignored; state stays HALTED until reset.
- MEM_TIMEOUT=8, MEM_DONE held 0 -> ERR=1 and HLT=1 after 8 held cycles in step 2. The condition clears only on reset.
- Reset asserted during a MEM wait -> the next edge gives IDLE outputs; a subsequent RUN restarts at step 0.
